// File: rtl/xbar_alloc.sv
// Crossbar request allocator: per-output round-robin arbitration that holds an output for a whole packet.
// grant/req are combinational from state and inputs; bad_dest is a registered per-input pulse.
module xbar_alloc #(
    parameter int XbarOutputs = 4,
    parameter int XbarInputs  = 4,
    parameter int DestWidth   = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [XbarInputs-1:0]             in_valid,
    input  logic [XbarInputs*DestWidth-1:0]   in_dest,
    input  logic [XbarInputs-1:0]             in_last,
    output logic [XbarInputs-1:0]             grant,
    output logic [XbarOutputs*XbarInputs-1:0] req,
    output logic [XbarInputs-1:0]             bad_dest
);
    localparam int IW = (XbarInputs > 1) ? $clog2(XbarInputs) : 1;
    localparam logic [DestWidth:0] OUT_LIM = (DestWidth+1)'(XbarOutputs);
    localparam logic [IW:0]        IN_CNT  = (IW+1)'(XbarInputs);
    localparam logic [0:0]         ST_FREE = 1'b0;
    localparam logic [0:0]         ST_BUSY = 1'b1;

    logic [XbarOutputs-1:0] state_q, state_d;
    logic [IW-1:0]          owner_q [XbarOutputs];
    logic [IW-1:0]          owner_d [XbarOutputs];
    logic [IW-1:0]          ptr_q   [XbarOutputs];
    logic [IW-1:0]          ptr_d   [XbarOutputs];
    logic [XbarInputs-1:0]  bad_dest_q, bad_dest_d;

    logic [XbarOutputs-1:0] want    [XbarInputs];
    logic [XbarOutputs-1:0] win_vld;
    logic [IW-1:0]          win_idx [XbarOutputs];
    logic [IW:0]            scan_sum;
    logic [IW-1:0]          scan_idx;

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] x);
        if (int'(x) == XbarInputs - 1) begin
            return '0;
        end
        return x + IW'(1);
    endfunction

    // Decode each input into a one-hot output request, or flag an out-of-range destination.
    always_comb begin
        for (int i = 0; i < XbarInputs; i++) begin
            want[i]       = '0;
            bad_dest_d[i] = 1'b0;
            if (in_valid[i]) begin
                if ({1'b0, in_dest[i*DestWidth +: DestWidth]} >= OUT_LIM) begin
                    bad_dest_d[i] = 1'b1;
                end else begin
                    for (int j = 0; j < XbarOutputs; j++) begin
                        if (in_dest[i*DestWidth +: DestWidth] == DestWidth'(j)) begin
                            want[i][j] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // A locked output only listens to its owner; a free one scans from its pointer.
    always_comb begin
        win_vld  = '0;
        win_idx  = '{default: '0};
        scan_sum = '0;
        scan_idx = '0;
        for (int j = 0; j < XbarOutputs; j++) begin
            if (state_q[j] == ST_BUSY) begin
                if (want[owner_q[j]][j]) begin
                    win_vld[j] = 1'b1;
                    win_idx[j] = owner_q[j];
                end
            end else begin
                for (int k = 0; k < XbarInputs; k++) begin
                    scan_sum = {1'b0, ptr_q[j]} + (IW+1)'(k);
                    if (scan_sum >= IN_CNT) begin
                        scan_sum = scan_sum - IN_CNT;
                    end
                    scan_idx = scan_sum[IW-1:0];
                    if (!win_vld[j] && want[scan_idx][j]) begin
                        win_vld[j] = 1'b1;
                        win_idx[j] = scan_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int j = 0; j < XbarOutputs; j++) begin
            if (win_vld[j] && !reset) begin
                grant[win_idx[j]] = 1'b1;
            end
        end
        req = '0;
        for (int i = 0; i < XbarInputs; i++) begin
            for (int j = 0; j < XbarOutputs; j++) begin
                req[i*XbarOutputs + j] = grant[i] && want[i][j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        for (int j = 0; j < XbarOutputs; j++) begin
            if (win_vld[j]) begin
                if (in_last[win_idx[j]]) begin
                    state_d[j] = ST_FREE;
                    ptr_d[j]   = rr_next(win_idx[j]);
                end else begin
                    state_d[j] = ST_BUSY;
                    owner_d[j] = win_idx[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '0;
            owner_q    <= '{default: '0};
            ptr_q      <= '{default: '0};
            bad_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            bad_dest_q <= bad_dest_d;
        end
    end

    assign bad_dest = bad_dest_q;

endmodule
